// File: rtl/code_sequencer.sv
// rtl/code_sequencer.sv - buffered 4-bit code message player with dwell/gap timing
module code_sequencer #(
  parameter int         DEPTH      = 8,
  parameter int         DIV_WIDTH  = 12,
  parameter logic [3:0] BLANK_CODE = 4'h0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load_valid,
  input  logic [3:0]             load_code,
  input  logic                   clear,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   loop,
  input  logic [DIV_WIDTH-1:0]   period,
  output logic [3:0]             code,
  output logic                   code_valid,
  output logic                   busy,
  output logic                   done,
  output logic [$clog2(DEPTH):0] length,
  output logic                   overflow
);

  localparam int IW = $clog2(DEPTH);
  localparam int LW = IW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t               state;
  logic [3:0]           mem [DEPTH];
  logic [IW-1:0]        index;
  logic [IW-1:0]        next_index;
  logic [DIV_WIDTH-1:0] cnt;
  logic [DIV_WIDTH-1:0] period_l;
  logic                 loop_l;

  logic is_idle, full, start_go, do_clear, do_load, dwell_end, last_entry;

  assign is_idle    = (state == IDLE);
  assign full       = (length == LW'(DEPTH));
  // A start only wins arbitration when there is something to play.
  assign start_go   = is_idle && start && (length != '0);
  assign do_clear   = is_idle && clear && !start_go;
  assign do_load    = is_idle && load_valid && !start_go && !clear;
  // Counter runs 0..period_l, so all-ones period never wraps the counter.
  assign dwell_end  = (cnt == period_l);
  assign next_index = index + 1'b1;
  assign last_entry = ({1'b0, index} == (length - 1'b1));

  // Message buffer write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (do_load && !full) begin
      mem[length[IW-1:0]] <= load_code;
    end
  end

  // Playback FSM with registered code/valid/busy/done and buffer bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      code       <= BLANK_CODE;
      code_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      length     <= '0;
      overflow   <= 1'b0;
      index      <= '0;
      cnt        <= '0;
      period_l   <= '0;
      loop_l     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start_go) begin
            state      <= SHOW;
            index      <= '0;
            cnt        <= '0;
            period_l   <= period;
            loop_l     <= loop;
            code       <= mem[0];
            code_valid <= 1'b1;
            busy       <= 1'b1;
          end else if (do_clear) begin
            length   <= '0;
            overflow <= 1'b0;
          end else if (do_load) begin
            if (full) overflow <= 1'b1;
            else      length   <= length + 1'b1;
          end
        end
        SHOW: begin
          if (stop) begin
            state      <= IDLE;
            code       <= BLANK_CODE;
            code_valid <= 1'b0;
            busy       <= 1'b0;
            index      <= '0;
            cnt        <= '0;
          end else if (dwell_end) begin
            state      <= GAP;
            cnt        <= '0;
            code       <= BLANK_CODE;
            code_valid <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        GAP: begin
          if (stop) begin
            state <= IDLE;
            busy  <= 1'b0;
            index <= '0;
            cnt   <= '0;
          end else if (dwell_end) begin
            cnt <= '0;
            if (!last_entry) begin
              state      <= SHOW;
              index      <= next_index;
              code       <= mem[next_index];
              code_valid <= 1'b1;
            end else if (loop_l) begin
              state      <= SHOW;
              index      <= '0;
              code       <= mem[0];
              code_valid <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
              index <= '0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          code       <= BLANK_CODE;
          code_valid <= 1'b0;
          busy       <= 1'b0;
          index      <= '0;
          cnt        <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_code_sequencer.sv
// tb/tb_code_sequencer.sv - scoreboard bench for code_sequencer
module tb_code_sequencer;

  localparam int DEPTH = 8;
  localparam int DW    = 12;

  logic          clk = 1'b0;
  logic          reset;
  logic          load_valid;
  logic [3:0]    load_code;
  logic          clear;
  logic          start;
  logic          stop;
  logic          loop;
  logic [DW-1:0] period;
  logic [3:0]    code;
  logic          code_valid;
  logic          busy;
  logic          done;
  logic [3:0]    length;
  logic          overflow;

  code_sequencer #(.DEPTH(DEPTH), .DIV_WIDTH(DW), .BLANK_CODE(4'h0)) dut (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_code(load_code),
    .clear(clear), .start(start), .stop(stop), .loop(loop), .period(period),
    .code(code), .code_valid(code_valid), .busy(busy), .done(done),
    .length(length), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] code;
    logic       valid;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [3:0] c, input logic v, input logic b, input logic d, input int n);
    exp_t e;
    e.code = c; e.valid = v; e.busy = b; e.done = d;
    repeat (n) sb.push_back(e);
  endtask

  task automatic drain(input string tag);
    exp_t e;
    exp_t o;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = {code, code_valid, busy, done};
      chk(tag, 32'(o), 32'(e));
      @(negedge clk);
    end
  endtask

  task automatic load(input logic [3:0] c);
    load_valid = 1'b1; load_code = c;
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  task automatic play(input logic [DW-1:0] p, input logic l);
    start = 1'b1; period = p; loop = l;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; load_valid = 1'b0; load_code = 4'h0; clear = 1'b0;
    start = 1'b0; stop = 1'b0; loop = 1'b0; period = '0;
    @(negedge clk);
    chk("rst_code", 32'(code), 32'h0);
    chk("rst_valid", 32'(code_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_length", 32'(length), 32'h0);
    chk("rst_overflow", 32'(overflow), 32'h0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", 32'(busy), 32'h0);

    // Three-entry non-looping message; period/loop changed mid-play must not matter
    load(4'h3); load(4'h7); load(4'h9);
    chk("len_three", 32'(length), 32'd3);
    push(4'h3, 1, 1, 0, 3); push(4'h0, 0, 1, 0, 3);
    push(4'h7, 1, 1, 0, 3); push(4'h0, 0, 1, 0, 3);
    push(4'h9, 1, 1, 0, 3); push(4'h0, 0, 1, 0, 3);
    push(4'h0, 0, 0, 1, 1); push(4'h0, 0, 0, 0, 1);
    play(12'd2, 1'b0);
    period = 12'd0; loop = 1'b1;
    drain("seq_nonloop");
    chk("len_after_play", 32'(length), 32'd3);
    loop = 1'b0;

    // Fill to DEPTH, overflow, verify buffer intact, then clear
    clear = 1'b1; @(negedge clk); clear = 1'b0;
    chk("clear_len", 32'(length), 32'd0);
    for (int i = 0; i < DEPTH; i++) load(4'(i + 1));
    chk("full_len", 32'(length), 32'(DEPTH));
    chk("full_no_ovf", 32'(overflow), 32'h0);
    load(4'hF);
    chk("ovf_len", 32'(length), 32'(DEPTH));
    chk("ovf_set", 32'(overflow), 32'h1);
    for (int i = 0; i < DEPTH; i++) begin
      push(4'(i + 1), 1, 1, 0, 1); push(4'h0, 0, 1, 0, 1);
    end
    push(4'h0, 0, 0, 1, 1);
    play(12'd0, 1'b0);
    drain("full_buf");
    chk("ovf_sticky", 32'(overflow), 32'h1);
    clear = 1'b1; load_valid = 1'b1; load_code = 4'h5;
    @(negedge clk);
    clear = 1'b0; load_valid = 1'b0;
    chk("clr_prio_len", 32'(length), 32'd0);
    chk("clr_ovf", 32'(overflow), 32'h0);

    // Start with empty buffer does nothing
    play(12'd0, 1'b0);
    chk("empty_start_busy", 32'(busy), 32'h0);
    chk("empty_start_code", 32'(code), 32'h0);

    // Looping two-entry message; same-cycle load is dropped
    load(4'hA); load(4'h5);
    repeat (2) begin
      push(4'hA, 1, 1, 0, 1); push(4'h0, 0, 1, 0, 1);
      push(4'h5, 1, 1, 0, 1); push(4'h0, 0, 1, 0, 1);
    end
    start = 1'b1; load_valid = 1'b1; load_code = 4'hC; period = 12'd0; loop = 1'b1;
    @(negedge clk);
    start = 1'b0; load_valid = 1'b0; loop = 1'b0;
    drain("loop_seq");
    chk("loop_len", 32'(length), 32'd2);
    load_valid = 1'b1; load_code = 4'hE; clear = 1'b1;
    @(negedge clk);
    load_valid = 1'b0; clear = 1'b0;
    chk("busy_ignore_len", 32'(length), 32'd2);
    chk("busy_ignore_ovf", 32'(overflow), 32'h0);
    chk("still_busy", 32'(busy), 32'h1);
    stop = 1'b1; @(negedge clk); stop = 1'b0;
    chk("stop_busy", 32'(busy), 32'h0);
    chk("stop_valid", 32'(code_valid), 32'h0);
    chk("stop_code", 32'(code), 32'h0);
    chk("stop_done", 32'(done), 32'h0);
    chk("stop_len", 32'(length), 32'd2);

    // Asynchronous reset during SHOW
    play(12'd5, 1'b0);
    @(negedge clk);
    chk("mid_show_valid", 32'(code_valid), 32'h1);
    #2 reset = 1'b1;
    #1;
    chk("async_code", 32'(code), 32'h0);
    chk("async_valid", 32'(code_valid), 32'h0);
    chk("async_busy", 32'(busy), 32'h0);
    chk("async_len", 32'(length), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Maximum period: 4096-cycle show and gap
    load(4'h6);
    push(4'h6, 1, 1, 0, 4096); push(4'h0, 0, 1, 0, 4096); push(4'h0, 0, 0, 1, 1);
    play(12'hFFF, 1'b0);
    drain("max_period");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
